// File: rtl/issue_scoreboard_ctrl.sv
// Decode-stage issue controller: tracks in-flight register writes in a busy
// scoreboard and stalls on RAW/WAW hazards, full write budget, or drain.
module issue_scoreboard_ctrl #(
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic             clk2,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic             id_regwrite,
  input  logic             wb_wr,
  input  logic [4:0]       wb_rd,
  input  logic             drain_req,
  output logic             issue,
  output logic             stall,
  output logic             drain_done,
  output logic [31:0]      busy_vec,
  output logic [5:0]       pending,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err_timeout,
  output logic             err_spur_wb
);

  localparam int RUN_W = $clog2(TIMEOUT + 1);
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {RUN, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [31:0]        busy_q, busy_d;
  logic [5:0]         pending_q, pending_d;
  logic [CNT_W-1:0]   stallCnt_q, stallCnt_d;
  logic [RUN_W-1:0]   stallRun_q, stallRun_d;
  logic               drainDone_q, drainDone_d;
  logic               errTimeout_q, errTimeout_d;
  logic               errSpur_q, errSpur_d;

  logic [6:0] op;
  logic [4:0] rd, rs1, rs2;
  logic       usesRs1, usesRs2, hazard;
  logic       unusedBits;

  assign op  = id_instr[6:0];
  assign rd  = id_instr[11:7];
  assign rs1 = id_instr[19:15];
  assign rs2 = id_instr[24:20];
  assign unusedBits = ^{id_instr[31:25], id_instr[14:12]};

  assign usesRs1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  assign usesRs2 = (op == OP_REG || op == OP_STORE || op == OP_BRANCH);

  // busy_q[0] is never set, so x0 sources fall out of the hazard terms naturally
  assign hazard = (usesRs1 & busy_q[rs1])
                | (usesRs2 & busy_q[rs2])
                | (id_regwrite & (rd != 5'd0) & busy_q[rd])
                | (id_regwrite & (rd != 5'd0) & (pending_q == 6'(MAX_PENDING)));

  always_ff @(posedge clk2) begin
    if (rst) begin
      state_q      <= RUN;
      busy_q       <= '0;
      pending_q    <= '0;
      stallCnt_q   <= '0;
      stallRun_q   <= '0;
      drainDone_q  <= 1'b0;
      errTimeout_q <= 1'b0;
      errSpur_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      pending_q    <= pending_d;
      stallCnt_q   <= stallCnt_d;
      stallRun_q   <= stallRun_d;
      drainDone_q  <= drainDone_d;
      errTimeout_q <= errTimeout_d;
      errSpur_q    <= errSpur_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (drain_req)  state_d = DRAIN;
      DRAIN:   if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    issue = 1'b0;
    if (state_q == RUN) issue = id_valid & !hazard & !drain_req;
  end

  assign stall = id_valid & !issue;

  // Clear before set so a same-register collision leaves the bit set
  always_comb begin
    busy_d    = busy_q;
    errSpur_d = errSpur_q;
    if (wb_wr && (wb_rd != 5'd0) && !busy_q[wb_rd]) errSpur_d = 1'b1;
    if (wb_wr) busy_d[wb_rd] = 1'b0;
    if (issue && id_regwrite && (rd != 5'd0)) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;

    pending_d = '0;
    for (int i = 0; i < 32; i++) pending_d = pending_d + {5'd0, busy_d[i]};

    drainDone_d = (state_d == DRAIN) && (busy_d == 32'd0);
  end

  always_comb begin
    stallCnt_d   = stallCnt_q;
    stallRun_d   = '0;
    errTimeout_d = errTimeout_q;
    if (stall) begin
      if (stallCnt_q != {CNT_W{1'b1}}) stallCnt_d = stallCnt_q + 1'b1;
      stallRun_d = (stallRun_q == RUN_W'(TIMEOUT)) ? stallRun_q : stallRun_q + 1'b1;
      if (stallRun_q >= RUN_W'(TIMEOUT - 1)) errTimeout_d = 1'b1;
    end
  end

  assign busy_vec    = busy_q;
  assign pending     = pending_q;
  assign stall_cnt   = stallCnt_q;
  assign drain_done  = drainDone_q;
  assign err_timeout = errTimeout_q;
  assign err_spur_wb = errSpur_q;

endmodule

// File: tb/tb_issue_scoreboard_ctrl.sv
// Bench for issue_scoreboard_ctrl: directed hazard scenarios plus random traffic,
// every cycle compared against a rule-level scoreboard model.
module tb_issue_scoreboard_ctrl;

  localparam int MAX_PENDING = 4;
  localparam int CNT_W       = 16;
  localparam int TIMEOUT     = 64;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;

  logic             clk2 = 1'b0;
  logic             rst;
  logic             idValid;
  logic [31:0]      idInstr;
  logic             idRegwrite;
  logic             wbWr;
  logic [4:0]       wbRd;
  logic             drainReq;
  logic             issue, stall, drainDone, errTimeout, errSpurWb;
  logic [31:0]      busyVec;
  logic [5:0]       pending;
  logic [CNT_W-1:0] stallCnt;

  int errCount   = 0;
  int checkCount = 0;

  // Reference model state
  bit mBusy[32];
  bit mDrain, mDone, mTimeout, mSpur;
  int mStallCnt, mRun;

  issue_scoreboard_ctrl #(.MAX_PENDING(MAX_PENDING), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk2(clk2), .rst(rst), .id_valid(idValid), .id_instr(idInstr),
    .id_regwrite(idRegwrite), .wb_wr(wbWr), .wb_rd(wbRd), .drain_req(drainReq),
    .issue(issue), .stall(stall), .drain_done(drainDone), .busy_vec(busyVec),
    .pending(pending), .stall_cnt(stallCnt), .err_timeout(errTimeout),
    .err_spur_wb(errSpurWb)
  );

  always #5 clk2 = ~clk2;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mkInstr(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), op};
  endfunction

  function automatic int mCount();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(mBusy[i]);
    return n;
  endfunction

  function automatic logic [31:0] mBusyVec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = mBusy[i];
    return v;
  endfunction

  function automatic bit mIssue();
    logic [6:0] op = idInstr[6:0];
    int rd  = int'(idInstr[11:7]);
    int rs1 = int'(idInstr[19:15]);
    int rs2 = int'(idInstr[24:20]);
    bit readsRs1 = !(op inside {OP_LUI, OP_AUI, OP_JAL});
    bit readsRs2 = op inside {OP_R, OP_S, OP_B};
    bit haz = 0;
    if (readsRs1 && rs1 != 0 && mBusy[rs1]) haz = 1;
    if (readsRs2 && rs2 != 0 && mBusy[rs2]) haz = 1;
    if (idRegwrite && rd != 0 && (mBusy[rd] || mCount() == MAX_PENDING)) haz = 1;
    return !mDrain && idValid && !haz && !drainReq;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mBusy[i] = 0;
    mDrain = 0; mDone = 0; mTimeout = 0; mSpur = 0; mStallCnt = 0; mRun = 0;
  endtask

  task automatic modelUpdate();
    bit iss, stl;
    int rd;
    if (rst) begin
      modelReset();
      return;
    end
    iss = mIssue();
    stl = idValid && !iss;
    rd  = int'(idInstr[11:7]);
    if (wbWr && wbRd != 0) begin
      if (!mBusy[wbRd]) mSpur = 1;
      mBusy[wbRd] = 0;
    end
    if (iss && idRegwrite && rd != 0) mBusy[rd] = 1;
    if (stl) begin
      if (mStallCnt < (1 << CNT_W) - 1) mStallCnt++;
      mRun++;
      if (mRun >= TIMEOUT) mTimeout = 1;
    end else begin
      mRun = 0;
    end
    mDrain = drainReq;
    mDone  = mDrain && mCount() == 0;
  endtask

  task automatic checkAll();
    bit expIssue = mIssue();
    checkOutput("issue", 64'(issue), 64'(expIssue));
    checkOutput("stall", 64'(stall), 64'(idValid && !expIssue));
    checkOutput("busy_vec", 64'(busyVec), 64'(mBusyVec()));
    checkOutput("pending", 64'(pending), 64'(mCount()));
    checkOutput("stall_cnt", 64'(stallCnt), 64'(mStallCnt));
    checkOutput("drain_done", 64'(drainDone), 64'(mDone));
    checkOutput("err_timeout", 64'(errTimeout), 64'(mTimeout));
    checkOutput("err_spur_wb", 64'(errSpurWb), 64'(mSpur));
  endtask

  // One cycle: inputs are set at the negedge, checked 1ns later, model steps at posedge
  task automatic applyStimulus(input bit v, input logic [31:0] instr, input bit rw,
                               input bit wr, input int wrd, input bit drain);
    idValid = v; idInstr = instr; idRegwrite = rw;
    wbWr = wr; wbRd = 5'(wrd); drainReq = drain;
    #1;
    checkAll();
    @(posedge clk2);
    modelUpdate();
    @(negedge clk2);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 32'd0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idValid = 0; idInstr = '0; idRegwrite = 0; wbWr = 0; wbRd = '0; drainReq = 0;
    @(posedge clk2);
    @(negedge clk2);
    modelReset();
    rst = 1'b0;
    checkOutput("reset_busy", 64'(busyVec), 64'd0);
    checkOutput("reset_state", 64'({drainDone, errTimeout, errSpurWb, pending, stallCnt}), 64'd0);

    $display("[TB] T1 RAW on x5");
    applyStimulus(1, mkInstr(OP_I, 5, 0, 0), 1, 0, 0, 0);
    applyStimulus(1, mkInstr(OP_R, 6, 5, 1), 1, 0, 0, 0);
    checkOutput("t1_busy", 64'(busyVec), 64'h20);
    applyStimulus(1, mkInstr(OP_R, 6, 5, 1), 1, 0, 0, 0);
    applyStimulus(1, mkInstr(OP_R, 6, 5, 1), 1, 1, 5, 0);
    applyStimulus(1, mkInstr(OP_R, 6, 5, 1), 1, 0, 0, 0);
    checkOutput("t1_stall_cnt", 64'(stallCnt), 64'd3);
    checkOutput("t1_busy_after", 64'(busyVec), 64'h40);

    $display("[TB] T2 pending limit");
    doReset();
    for (int r = 1; r <= 4; r++) applyStimulus(1, mkInstr(OP_LUI, r, 0, 0), 1, 0, 0, 0);
    checkOutput("t2_pending", 64'(pending), 64'd4);
    applyStimulus(1, mkInstr(OP_LUI, 7, 0, 0), 1, 0, 0, 0);
    applyStimulus(1, mkInstr(OP_LUI, 7, 0, 0), 1, 1, 1, 0);
    applyStimulus(1, mkInstr(OP_LUI, 7, 0, 0), 1, 0, 0, 0);
    checkOutput("t2_busy", 64'(busyVec), 64'h9C);

    $display("[TB] T3 WAW");
    doReset();
    applyStimulus(1, mkInstr(OP_LUI, 9, 0, 0), 1, 0, 0, 0);
    applyStimulus(1, mkInstr(OP_LUI, 9, 0, 0), 1, 0, 0, 0);
    applyStimulus(1, mkInstr(OP_LUI, 10, 0, 0), 1, 0, 0, 0);
    checkOutput("t3_busy", 64'(busyVec), 64'h600);

    $display("[TB] T4 drain");
    doReset();
    applyStimulus(1, mkInstr(OP_LUI, 1, 0, 0), 1, 0, 0, 0);
    applyStimulus(1, mkInstr(OP_LUI, 2, 0, 0), 1, 0, 0, 0);
    applyStimulus(1, mkInstr(OP_LUI, 3, 0, 0), 1, 0, 0, 1);
    checkOutput("t4_not_done", 64'(drainDone), 64'd0);
    applyStimulus(1, mkInstr(OP_LUI, 3, 0, 0), 1, 1, 1, 1);
    applyStimulus(1, mkInstr(OP_LUI, 3, 0, 0), 1, 1, 2, 1);
    checkOutput("t4_done", 64'(drainDone), 64'd1);
    applyStimulus(1, mkInstr(OP_LUI, 3, 0, 0), 1, 0, 0, 0);
    applyStimulus(1, mkInstr(OP_LUI, 3, 0, 0), 1, 0, 0, 0);
    checkOutput("t4_resumed", 64'(busyVec), 64'h8);

    $display("[TB] T5 spurious writeback and timeout");
    doReset();
    applyStimulus(0, 32'd0, 0, 1, 3, 0);
    checkOutput("t5_spur", 64'(errSpurWb), 64'd1);
    applyStimulus(1, mkInstr(OP_LUI, 1, 0, 0), 1, 0, 0, 0);
    for (int c = 0; c < TIMEOUT - 1; c++) applyStimulus(1, mkInstr(OP_R, 2, 1, 0), 1, 0, 0, 0);
    checkOutput("t5_no_timeout_yet", 64'(errTimeout), 64'd0);
    applyStimulus(1, mkInstr(OP_R, 2, 1, 0), 1, 0, 0, 0);
    checkOutput("t5_timeout", 64'(errTimeout), 64'd1);

    $display("[TB] T6 reset mid-stall and x0 reader");
    doReset();
    for (int r = 4; r <= 7; r++) applyStimulus(1, mkInstr(OP_LUI, r, 0, 0), 1, 0, 0, 0);
    checkOutput("t6_busy", 64'(busyVec), 64'hF0);
    rst = 1'b1;
    applyStimulus(1, mkInstr(OP_R, 1, 4, 0), 1, 0, 0, 0);
    rst = 1'b0;
    checkOutput("t6_reset_busy", 64'(busyVec), 64'd0);
    checkOutput("t6_reset_cnt", 64'(stallCnt), 64'd0);
    applyStimulus(1, mkInstr(OP_R, 1, 0, 0), 1, 0, 0, 0);
    checkOutput("t6_x0_reader", 64'(busyVec), 64'h2);

    $display("[TB] random traffic");
    doReset();
    begin
      logic [6:0] ops[7] = '{OP_R, OP_I, OP_LUI, OP_AUI, OP_JAL, OP_S, OP_B};
      bit drain = 0;
      for (int n = 0; n < 600; n++) begin
        logic [6:0] op = ops[$urandom_range(6)];
        bit wr = 0;
        int wrd = 0;
        if ($urandom_range(99) < 5) drain = !drain;
        if ($urandom_range(1) == 1) begin
          int start = $urandom_range(31);
          for (int k = 0; k < 32; k++) begin
            if (!wr && mBusy[(start + k) % 32]) begin
              wr = 1;
              wrd = (start + k) % 32;
            end
          end
        end
        if ($urandom_range(99) < 3) begin
          wr = 1;
          wrd = $urandom_range(7);
        end
        rst = ($urandom_range(199) == 0);
        applyStimulus($urandom_range(3) != 0, mkInstr(op, $urandom_range(7), $urandom_range(7),
                      $urandom_range(7)), !(op inside {OP_S, OP_B}), wr, wrd, drain);
        rst = 1'b0;
      end
    end
    #1;
    checkAll();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
